slip_rx: RTL and testbench
==========================

// Module: slip_rx
// PURPOSE
//  SLIP (RFC 1055) frame decoder that drains the byte FIFO of the UART receiver.
//  It pops raw line bytes, strips END (C0) delimiters and undoes ESC (DB) sequences.
//  It emits decoded payload bytes on a valid/ready stream: last marks end of frame, err marks a bad frame.
//  It sits between the UART RX FIFO and the packet/command layer.
// PARAMETERS
//  MAXLEN  256  max payload bytes per frame; longer frames are aborted with err
//  LW      $clog2(MAXLEN+1), localparam  width of out_len
// PORTS
//  clock      in   1   single clock; all state changes on posedge
//  reset      in   1   synchronous, active-high
//  in         in   8   raw byte at FIFO head, valid while ~empty
//  empty      in   1   FIFO empty
//  get        out  1   pop FIFO head on this posedge (combinational)
//  out        out  8   decoded byte
//  out_last   out  1   out is the final byte of the frame
//  out_err    out  1   frame aborted (with out_last=1)
//  out_len    out  LW  payload byte count incl. this byte; meaningful when out_last
//  out_valid  out  1   output register holds a byte
//  out_ready  in   1   consumer accepts the byte on this posedge
// BEHAVIOUR
//  - Reset: out_valid=0, out_last=0, out_err=0, out=0, out_len=0, held=0, count=0, state=HUNT.
//  - Pop rule: get = ~empty & (~out_valid | out_ready). Each pop yields 0 or 1 emission; the emission appears on out_valid the next cycle (1-cycle latency).
//  - Output register: while out_valid & ~out_ready, out/out_last/out_err/out_len hold stable.
//  - One-byte hold register H: needed because last is known only when END arrives.
//  - States (s = popped byte):
//    HUNT: discard all bytes until s=C0, then go to DATA. Provides frame sync after reset or an error.
//    DATA:
//      s=C0, H valid: emit H with last=1, len=count; clear H; count=0.
//      s=C0, H empty: empty frame; emit nothing.
//      s=DB: go to ESC.
//      other s: if H valid, emit H (last=0); H<=s; count+=1.
//    ESC:
//      s=DC: decoded byte C0; handle as a data byte; return to DATA.
//      s=DD: decoded byte DB; handle as a data byte; return to DATA.
//      s=C0: abort, then go to DATA, since this END begins the next frame.
//      other s: abort, then go to HUNT.
//  - Abort: emit last=1, err=1, len=count. Byte is H if H valid, else 00. Then clear H and count.
//  - Overflow: a data byte arriving when count==MAXLEN is dropped. Abort as above, then go to HUNT.
//  - count saturates at MAXLEN and never wraps. A frame of exactly MAXLEN bytes is legal.
//  - Simultaneous pop and out_ready in one cycle: the new emission replaces the accepted one with no bubble. Full throughput is 1 byte/clock.
//  - Reset mid-frame: the partial frame is discarded with no last/err emitted, and the block re-enters HUNT.
//  - FIFO empty mid-frame: no timeout; H is held indefinitely.
// STRUCTURE
//  - slip.vh: `define SLIP_END 8'hC0, SLIP_ESC 8'hDB, SLIP_ESC_END 8'hDC, SLIP_ESC_ESC 8'hDD. Shared with the future slip_tx.
//  - Single module: FSM, H register, count and output register. No sub-module.
//  - Top-level pairing is uart_rx_fifo -> slip_rx, wired directly to its out/get/empty.
// TESTING
//  1. After reset, feed 11 C0 22 33 C0 with out_ready=1.
//     11 is dropped in HUNT. Expect 22(last=0), then 33(last=1, err=0, len=2).
//  2. Feed C0 DB DC DB DD 41 C0.
//     Expect C0, DB, 41 with last on 41, len=3.
//     Then C0 C0: expect no emission.
//  3. Feed C0 55 DB 99 66 C0 77 C0.
//     Expect 55(last=1, err=1, len=1); 66 is discarded in HUNT; then 77(last=1, len=1).
//     Then C0 DB C0 88 C0: expect 00(last=1, err=1, len=0), then 88(last=1).
//  4. With MAXLEN=4, feed C0 01 02 03 04 05 06 C0 0A C0.
//     Expect 01 02 03 then 04(last=1, err=1, len=4); 05/06 discarded; C0 0A C0 -> 0A(last=1, len=1).
//     Exactly 4 bytes then C0 must pass with err=0.
//  5. Backpressure: hold out_ready=0 for 5 cycles mid-frame.
//     Expect get=0 and out stable during the stall, and no byte lost or duplicated.
//     Toggle out_ready 1/0 randomly over a 200-byte frame: the received stream equals the sent stream.
//  6. Assert reset during a frame after 3 data bytes.
//     Expect out_valid=0 next cycle, no last/err emitted, and the next C0 AA C0 yields AA(last=1, len=1).

Source files
------------

// File: rtl/slip_rx_pkg.sv
// SLIP framing constants and receiver state encoding.
// Shared by slip_rx and the future slip_tx so both sides agree on the
// special byte values.
package slip_rx_pkg;

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,  // discarding bytes until an END gives frame sync
        ST_DATA = 2'd1,  // inside a frame, plain bytes
        ST_ESC  = 2'd2   // previous byte was ESC
    } state_e;

endpackage

// File: rtl/slip_rx.sv
// SLIP (RFC 1055) frame decoder draining a UART RX byte FIFO.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   in, empty, get        FIFO head byte, FIFO empty flag, pop strobe
//   out, out_last,        decoded byte, end-of-frame flag,
//   out_err, out_len      aborted-frame flag, payload count (valid with last)
//   out_valid, out_ready  output stream handshake
//
// Handshake: a byte transfers on a posedge where out_valid and out_ready
// are both high. While out_valid is high and out_ready low, the output
// fields hold stable. A FIFO byte is popped whenever the output register
// is free or being drained this cycle, so throughput is one byte per clock.
//
// A one-byte hold register (h) delays every payload byte by one position,
// because a byte can only be marked last once the following END is seen.
module slip_rx
    import slip_rx_pkg::*;
#(
    parameter  int MAXLEN = 256,
    localparam int LW     = $clog2(MAXLEN + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    in,
    input  logic          empty,
    output logic          get,
    output logic [7:0]    out,
    output logic          out_last,
    output logic          out_err,
    output logic [LW-1:0] out_len,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam logic [LW-1:0] MAX_CNT = LW'(MAXLEN);

    state_e        state_q, state_d;
    logic [7:0]    h_q, h_d;
    logic          h_valid_q, h_valid_d;
    logic [LW-1:0] count_q, count_d;
    logic [7:0]    out_q, out_d;
    logic          out_last_q, out_last_d;
    logic          out_err_q, out_err_d;
    logic [LW-1:0] out_len_q, out_len_d;
    logic          out_valid_q, out_valid_d;

    logic          take_data;
    logic [7:0]    data_byte;
    logic          abort;
    logic          abort_to_data;
    logic          emit;
    logic [7:0]    emit_byte;
    logic          emit_last;
    logic          emit_err;

    assign get       = ~empty & (~out_valid_q | out_ready);
    assign out       = out_q;
    assign out_last  = out_last_q;
    assign out_err   = out_err_q;
    assign out_len   = out_len_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        h_valid_d     = h_valid_q;
        count_d       = count_q;
        out_d         = out_q;
        out_last_d    = out_last_q;
        out_err_d     = out_err_q;
        out_len_d     = out_len_q;
        out_valid_d   = out_valid_q & ~out_ready;
        take_data     = 1'b0;
        data_byte     = in;
        abort         = 1'b0;
        abort_to_data = 1'b0;
        emit          = 1'b0;
        emit_byte     = h_q;
        emit_last     = 1'b0;
        emit_err      = 1'b0;

        if (get) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (in == SLIP_END) state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (in == SLIP_END) begin
                        // END with an empty hold register is an empty frame.
                        if (h_valid_q) begin
                            emit      = 1'b1;
                            emit_last = 1'b1;
                            h_valid_d = 1'b0;
                            count_d   = '0;
                        end
                    end else if (in == SLIP_ESC) begin
                        state_d = ST_ESC;
                    end else begin
                        take_data = 1'b1;
                    end
                end
                ST_ESC: begin
                    if (in == SLIP_ESC_END) begin
                        take_data = 1'b1;
                        data_byte = SLIP_END;
                    end else if (in == SLIP_ESC_ESC) begin
                        take_data = 1'b1;
                        data_byte = SLIP_ESC;
                    end else begin
                        abort = 1'b1;
                        // An END after ESC still opens the next frame.
                        abort_to_data = (in == SLIP_END);
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        if (take_data) begin
            if (count_q == MAX_CNT) begin
                // No room for another byte: the frame is too long.
                abort = 1'b1;
            end else begin
                emit      = h_valid_q;
                h_d       = data_byte;
                h_valid_d = 1'b1;
                count_d   = count_q + LW'(1);
                state_d   = ST_DATA;
            end
        end

        if (abort) begin
            emit      = 1'b1;
            emit_byte = h_valid_q ? h_q : 8'h00;
            emit_last = 1'b1;
            emit_err  = 1'b1;
            h_valid_d = 1'b0;
            count_d   = '0;
            state_d   = abort_to_data ? ST_DATA : ST_HUNT;
        end

        // The held byte is always byte number count_q of the frame.
        if (emit) begin
            out_d       = emit_byte;
            out_last_d  = emit_last;
            out_err_d   = emit_err;
            out_len_d   = count_q;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            h_q         <= 8'h00;
            h_valid_q   <= 1'b0;
            count_q     <= '0;
            out_q       <= 8'h00;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            h_valid_q   <= h_valid_d;
            count_q     <= count_d;
            out_q       <= out_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
            out_len_q   <= out_len_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_slip_rx.sv
// Bench for slip_rx: a 256-byte-limit instance (a) and a 4-byte-limit
// instance (b). A byte queue models the UART FIFO of the selected instance;
// decoded bytes are compared in order against an expected queue.
module tb_slip_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       out_ready = 1'b0;

    logic [7:0] in_a = 8'h00, in_b = 8'h00;
    logic       empty_a = 1'b1, empty_b = 1'b1;
    logic       get_a, get_b;
    logic [7:0] out_a, out_b;
    logic       out_last_a, out_last_b, out_err_a, out_err_b;
    logic       out_valid_a, out_valid_b;
    logic [8:0] out_len_a;
    logic [2:0] out_len_b;

    slip_rx #(.MAXLEN(256)) dut_a (
        .clock(clk), .reset(reset), .in(in_a), .empty(empty_a), .get(get_a),
        .out(out_a), .out_last(out_last_a), .out_err(out_err_a),
        .out_len(out_len_a), .out_valid(out_valid_a), .out_ready(out_ready)
    );

    slip_rx #(.MAXLEN(4)) dut_b (
        .clock(clk), .reset(reset), .in(in_b), .empty(empty_b), .get(get_b),
        .out(out_b), .out_last(out_last_b), .out_err(out_err_b),
        .out_len(out_len_b), .out_valid(out_valid_b), .out_ready(out_ready)
    );

    // clock / reset
    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    int         extra = 0;
    int         sel = 0;        // 0 = dut_a, 1 = dut_b
    int         ready_mode = 0; // 0 = always ready, 1 = random, 2 = stalled
    logic [7:0] line_q[$];
    logic [18:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // {err, last, len (only when last), data}
    function automatic logic [18:0] mk(input logic [7:0] d, input logic l, input logic e, input int len);
        return {e, l, (l ? 9'(len) : 9'd0), d};
    endfunction

    // FIFO model and output monitor. Inputs change on negedge; everything
    // read at negedge+1 is what the DUT sees at the next posedge.
    always @(negedge clk) begin
        logic       v, l, e, g;
        logic [7:0] d;
        logic [8:0] n;
        logic [18:0] got, exp;
        empty_a = 1'b1; in_a = 8'h00;
        empty_b = 1'b1; in_b = 8'h00;
        if (line_q.size() > 0) begin
            if (sel == 0) begin empty_a = 1'b0; in_a = line_q[0]; end
            else          begin empty_b = 1'b0; in_b = line_q[0]; end
        end
        out_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : (ready_mode == 0);
        #1;
        g = (sel == 0) ? get_a : get_b;
        v = (sel == 0) ? out_valid_a : out_valid_b;
        d = (sel == 0) ? out_a : out_b;
        l = (sel == 0) ? out_last_a : out_last_b;
        e = (sel == 0) ? out_err_a : out_err_b;
        n = (sel == 0) ? out_len_a : 9'(out_len_b);
        if (g && !reset) void'(line_q.pop_front());
        if (v && out_ready && !reset) begin
            got = {e, l, (l ? n : 9'd0), d};
            if (exp_q.size() == 0) begin
                extra++;
                $display("unexpected byte %0h", got);
            end else begin
                exp = exp_q.pop_front();
                check("stream byte", 32'(got), 32'(exp));
            end
        end
    end

    // driver tasks
    task automatic push_line(input logic [7:0] b);
        line_q.push_back(b);
    endtask

    task automatic push_list(input logic [7:0] bytes[]);
        foreach (bytes[i]) line_q.push_back(bytes[i]);
    endtask

    task automatic send_payload_byte(input logic [7:0] b);
        if (b == 8'hC0)      begin push_line(8'hDB); push_line(8'hDC); end
        else if (b == 8'hDB) begin push_line(8'hDB); push_line(8'hDD); end
        else                 push_line(b);
    endtask

    task automatic drain(input string tag);
        logic v;
        int   k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk); #2;
            v = (sel == 0) ? out_valid_a : out_valid_b;
            if (line_q.size() == 0 && exp_q.size() == 0 && !v) break;
        end
        repeat (3) @(negedge clk);
        #2;
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] pay[200];

        // reset
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        check("reset valid a", 32'(out_valid_a), 0);
        check("reset out a", 32'(out_a), 0);
        check("reset last a", 32'(out_last_a), 0);
        check("reset err a", 32'(out_err_a), 0);
        check("reset len a", 32'(out_len_a), 0);
        check("reset valid b", 32'(out_valid_b), 0);
        check("reset len b", 32'(out_len_b), 0);
        reset = 1'b0;
        @(negedge clk); #2;
        check("idle get a", 32'(get_a), 0);

        // 1: hunt then a two-byte frame
        exp_q.push_back(mk(8'h22, 0, 0, 0));
        exp_q.push_back(mk(8'h33, 1, 0, 2));
        push_list('{8'h11, 8'hC0, 8'h22, 8'h33, 8'hC0});
        drain("t1 frame");

        // 2: escapes, then empty frames
        exp_q.push_back(mk(8'hC0, 0, 0, 0));
        exp_q.push_back(mk(8'hDB, 0, 0, 0));
        exp_q.push_back(mk(8'h41, 1, 0, 3));
        push_list('{8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'h41, 8'hC0});
        drain("t2 escapes");
        push_list('{8'hC0, 8'hC0});
        drain("t2 empty frames");

        // 3: bad escape aborts, END after ESC resyncs at once
        exp_q.push_back(mk(8'h55, 1, 1, 1));
        exp_q.push_back(mk(8'h77, 1, 0, 1));
        push_list('{8'hC0, 8'h55, 8'hDB, 8'h99, 8'h66, 8'hC0, 8'h77, 8'hC0});
        drain("t3 bad escape");
        exp_q.push_back(mk(8'h00, 1, 1, 0));
        exp_q.push_back(mk(8'h88, 1, 0, 1));
        push_list('{8'hC0, 8'hDB, 8'hC0, 8'h88, 8'hC0});
        drain("t3 esc end");

        // 4: overflow on the 4-byte instance, then an exactly-full frame
        sel = 1;
        exp_q.push_back(mk(8'h01, 0, 0, 0));
        exp_q.push_back(mk(8'h02, 0, 0, 0));
        exp_q.push_back(mk(8'h03, 0, 0, 0));
        exp_q.push_back(mk(8'h04, 1, 1, 4));
        exp_q.push_back(mk(8'h0A, 1, 0, 1));
        push_list('{8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hC0, 8'h0A, 8'hC0});
        drain("t4 overflow");
        exp_q.push_back(mk(8'h11, 0, 0, 0));
        exp_q.push_back(mk(8'h22, 0, 0, 0));
        exp_q.push_back(mk(8'h33, 0, 0, 0));
        exp_q.push_back(mk(8'h44, 1, 0, 4));
        push_list('{8'hC0, 8'h11, 8'h22, 8'h33, 8'h44, 8'hC0});
        drain("t4 full frame");
        sel = 0;

        // 5: stall mid-frame
        exp_q.push_back(mk(8'hA1, 0, 0, 0));
        exp_q.push_back(mk(8'hA2, 0, 0, 0));
        exp_q.push_back(mk(8'hA3, 0, 0, 0));
        exp_q.push_back(mk(8'hA4, 1, 0, 4));
        ready_mode = 2;
        push_list('{8'hC0, 8'hA1, 8'hA2, 8'hA3});
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            check("stall get", 32'(get_a), 0);
            check("stall valid", 32'(out_valid_a), 1);
            check("stall out", 32'(out_a), 32'hA1);
        end
        ready_mode = 0;
        push_list('{8'hA4, 8'hC0});
        drain("t5 stall frame");

        // 5b: random backpressure over a 200-byte frame
        ready_mode = 1;
        push_line(8'hC0);
        for (int i = 0; i < 200; i++) begin
            pay[i] = (i % 37 == 5) ? 8'hC0 : (i % 41 == 7) ? 8'hDB : 8'($urandom_range(0, 255));
            send_payload_byte(pay[i]);
            exp_q.push_back(mk(pay[i], (i == 199), 0, 200));
        end
        push_line(8'hC0);
        drain("t5 random ready");
        ready_mode = 0;

        // 6: reset mid-frame discards the partial frame
        exp_q.push_back(mk(8'h01, 0, 0, 0));
        exp_q.push_back(mk(8'h02, 0, 0, 0));
        push_list('{8'hC0, 8'h01, 8'h02, 8'h03});
        drain("t6 before reset");
        reset = 1'b1;
        @(negedge clk); #2;
        check("t6 valid in reset", 32'(out_valid_a), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("t6 valid after reset", 32'(out_valid_a), 0);
        exp_q.push_back(mk(8'hAA, 1, 0, 1));
        push_list('{8'hC0, 8'hAA, 8'hC0});
        drain("t6 after reset");

        check("no extra bytes", 32'(extra), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
